// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3-style memory responder backed by a word-organised SRAM array.
//   Independent read (AR/R) and write (AW/W/B) engines each accept one
//   outstanding transaction at a time; FIXED and INCR bursts of up to 16
//   beats are supported, every beat is treated as a full 32-bit word.
//
// Parameters
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//   DEPTH_WORDS  number of 32-bit words (power of two, 16..65536)
//
// Ports
//   aclk, areset                    clock (rising edge), async active-high reset
//   ar*  (arid .. arvalid/arready)  read command channel
//   r*   (rid .. rvalid/rready)     read data channel, registered outputs
//   aw*  (awid .. awvalid/awready)  write command channel
//   w*   (wdata .. wvalid/wready)   write data channel
//   b*   (bid .. bvalid/bready)     write response channel
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic {
        R_IDLE,
        R_BEAT
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    // Storage is deliberately not reset.
    logic [31:0] mem [DEPTH_WORDS];

    // Signals the protocol carries but this responder does not use.
    logic unused_inputs;
    assign unused_inputs = ^{arsize, arlen[7:4], awlen[7:4]};

    // The 33-bit subtraction exposes the borrow, so "below BASE_ADDR" needs
    // no separate compare.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[32] && ((diff[31:0] >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // Only burst encodings 0 (FIXED) and 1 (INCR) are legal.
    function automatic logic burst_ok(input logic [1:0] burst);
        return !burst[1];
    endfunction

    function automatic logic [31:0] beat_advance(input logic [31:0] addr,
                                                 input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd4;
    endfunction

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_t   rd_state_q, rd_state_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [3:0]  rlen_q, rlen_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic        rd_load;
    logic [31:0] rd_load_addr;
    logic [1:0]  rd_load_burst;
    logic        rd_load_ok;

    // A beat is fetched straight from the array into the R registers either on
    // the AR handshake (beat 0) or on an R handshake that is not the last.
    // The array is read before this edge's write lands, so a write in the same
    // cycle is only seen by later beats.
    always_comb begin
        rd_state_d    = rd_state_q;
        rid_d         = rid_q;
        raddr_d       = raddr_q;
        rlen_d        = rlen_q;
        rburst_d      = rburst_q;
        rcnt_d        = rcnt_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rlast_d       = rlast_q;
        rd_load       = 1'b0;
        rd_load_addr  = raddr_q;
        rd_load_burst = rburst_q;

        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d         = arid;
                    raddr_d       = araddr;
                    rlen_d        = arlen[3:0];
                    rburst_d      = arburst;
                    rcnt_d        = 4'd0;
                    rlast_d       = (arlen[3:0] == 4'd0);
                    rd_load       = 1'b1;
                    rd_load_addr  = araddr;
                    rd_load_burst = arburst;
                    rd_state_d    = R_BEAT;
                end
            end
            R_BEAT: begin
                if (rready) begin
                    if (rcnt_q == rlen_q) begin
                        rlast_d    = 1'b0;
                        rd_state_d = R_IDLE;
                    end else begin
                        raddr_d      = beat_advance(raddr_q, rburst_q);
                        rcnt_d       = rcnt_q + 4'd1;
                        rlast_d      = (rcnt_d == rlen_q);
                        rd_load      = 1'b1;
                        rd_load_addr = raddr_d;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        rd_load_ok = burst_ok(rd_load_burst) && addr_in_range(rd_load_addr);
        if (rd_load) begin
            rdata_d = rd_load_ok ? mem[word_index(rd_load_addr)] : 32'd0;
            rresp_d = rd_load_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            rid_q      <= 4'd0;
            raddr_q    <= 32'd0;
            rlen_q     <= 4'd0;
            rburst_q   <= 2'd0;
            rcnt_q     <= 4'd0;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rburst_q   <= rburst_d;
            rcnt_q     <= rcnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    assign arready = (rd_state_q == R_IDLE);
    assign rvalid  = (rd_state_q == R_BEAT);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_t   wr_state_q, wr_state_d;
    logic [3:0]  bid_q, bid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [3:0]  wlen_q, wlen_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        werr_q, werr_d;
    logic [1:0]  bresp_q, bresp_d;

    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic             wr_beat_ok;

    // The beat counter, not wlast, decides when the burst ends; a wlast that
    // disagrees with the counter only poisons the response. Bad beats are
    // dropped but the burst still runs to completion.
    always_comb begin
        wr_state_d = wr_state_q;
        bid_d      = bid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        mem_idx    = word_index(waddr_q);
        wr_beat_ok = burst_ok(wburst_q) && addr_in_range(waddr_q);

        case (wr_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    bid_d      = awid;
                    waddr_d    = awaddr;
                    wlen_d     = awlen[3:0];
                    wburst_d   = awburst;
                    wcnt_d     = 4'd0;
                    werr_d     = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we = wr_beat_ok;
                    werr_d = werr_q || !wr_beat_ok || (wlast != (wcnt_q == wlen_q));
                    if (wcnt_q == wlen_q) begin
                        bresp_d    = werr_d ? RESP_SLVERR : RESP_OKAY;
                        wr_state_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 4'd1;
                        waddr_d = beat_advance(waddr_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            bid_q      <= 4'd0;
            waddr_q    <= 32'd0;
            wlen_q     <= 4'd0;
            wburst_q   <= 2'd0;
            wcnt_q     <= 4'd0;
            werr_q     <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wburst_q   <= wburst_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
            bresp_q    <= bresp_d;
        end
    end

    // Byte-lane writes into the array; kept in a clock-only process so it
    // maps onto a plain RAM. Writes are gated by the write state, which reset
    // forces to idle.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign awready = (wr_state_q == W_IDLE);
    assign wready  = (wr_state_q == W_DATA);
    assign bvalid  = (wr_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule
